// File: rtl/bus_pkg.sv
// Shared datapath bus constants: widths and bus-source indices
// used by the bus multiplexer and the destination register bank.
package bus_pkg;

    localparam int WIDTH       = 32;
    localparam int SEL_W       = 5;
    localparam int NUM_GPR     = 16;
    localparam int NUM_SOURCES = 25;

    localparam logic [SEL_W-1:0] SEL_R0     = 5'd0;
    localparam logic [SEL_W-1:0] SEL_R1     = 5'd1;
    localparam logic [SEL_W-1:0] SEL_R2     = 5'd2;
    localparam logic [SEL_W-1:0] SEL_R3     = 5'd3;
    localparam logic [SEL_W-1:0] SEL_R4     = 5'd4;
    localparam logic [SEL_W-1:0] SEL_R5     = 5'd5;
    localparam logic [SEL_W-1:0] SEL_R6     = 5'd6;
    localparam logic [SEL_W-1:0] SEL_R7     = 5'd7;
    localparam logic [SEL_W-1:0] SEL_R8     = 5'd8;
    localparam logic [SEL_W-1:0] SEL_R9     = 5'd9;
    localparam logic [SEL_W-1:0] SEL_R10    = 5'd10;
    localparam logic [SEL_W-1:0] SEL_R11    = 5'd11;
    localparam logic [SEL_W-1:0] SEL_R12    = 5'd12;
    localparam logic [SEL_W-1:0] SEL_R13    = 5'd13;
    localparam logic [SEL_W-1:0] SEL_R14    = 5'd14;
    localparam logic [SEL_W-1:0] SEL_R15    = 5'd15;
    localparam logic [SEL_W-1:0] SEL_HI     = 5'd16;
    localparam logic [SEL_W-1:0] SEL_LO     = 5'd17;
    localparam logic [SEL_W-1:0] SEL_Y      = 5'd18;
    localparam logic [SEL_W-1:0] SEL_ZHIGH  = 5'd19;
    localparam logic [SEL_W-1:0] SEL_ZLOW   = 5'd20;
    localparam logic [SEL_W-1:0] SEL_PC     = 5'd21;
    localparam logic [SEL_W-1:0] SEL_MDR    = 5'd22;
    localparam logic [SEL_W-1:0] SEL_INPORT = 5'd23;
    localparam logic [SEL_W-1:0] SEL_CSIGN  = 5'd24;
    localparam logic [SEL_W-1:0] SEL_NONE   = 5'd31;

endpackage

// File: rtl/bus_dest_bank_if.sv
// Load-enable / register-value bundle between control, bus mux
// and the destination register bank.
interface bus_dest_bank_if;
    import bus_pkg::*;

    logic [WIDTH-1:0]         bus_in;
    logic [2*WIDTH-1:0]       alu_result;
    logic [NUM_GPR-1:0]       r_in;
    logic                     hi_in;
    logic                     lo_in;
    logic                     y_in;
    logic                     pc_in;
    logic                     z_in;
    logic                     pc_inc;
    logic [NUM_SOURCES-1:0]   out_en;

    logic [NUM_GPR*WIDTH-1:0] gpr_q;
    logic [WIDTH-1:0]         hi_q;
    logic [WIDTH-1:0]         lo_q;
    logic [WIDTH-1:0]         y_q;
    logic [WIDTH-1:0]         pc_q;
    logic [WIDTH-1:0]         zhigh_q;
    logic [WIDTH-1:0]         zlow_q;
    logic [SEL_W-1:0]         bus_select;
    logic                     multi_drive;

    modport master (
        output bus_in, alu_result, r_in,
        output hi_in, lo_in, y_in, pc_in, z_in, pc_inc,
        output out_en,
        input  gpr_q, hi_q, lo_q, y_q, pc_q,
        input  zhigh_q, zlow_q, bus_select, multi_drive
    );

    modport slave (
        input  bus_in, alu_result, r_in,
        input  hi_in, lo_in, y_in, pc_in, z_in, pc_inc,
        input  out_en,
        output gpr_q, hi_q, lo_q, y_q, pc_q,
        output zhigh_q, zlow_q, bus_select, multi_drive
    );

endinterface

// File: rtl/bus_select_encoder.sv
// Lowest-index-wins encoder from one-hot out enables to the bus
// source select, plus a combinational "more than one driver" flag.
module bus_select_encoder
    import bus_pkg::*;
(
    input  logic [NUM_SOURCES-1:0] i_out_en,
    output logic [SEL_W-1:0]       o_sel,
    output logic                   o_multi_hot
);

    logic [NUM_SOURCES-1:0] w_rest;

    // Scanning downward lets the lowest set bit land last.
    always_comb begin
        o_sel = SEL_NONE;
        for (int k = NUM_SOURCES - 1; k >= 0; k--) begin
            if (i_out_en[k]) begin
                o_sel = SEL_W'(k);
            end
        end
    end

    // Clearing the lowest set bit leaves something only if multi-hot.
    assign w_rest      = i_out_en & (i_out_en - NUM_SOURCES'(1));
    assign o_multi_hot = |w_rest;

endmodule

// File: rtl/bus_dest_bank.sv
// Bus destination register bank: R0-R15, HI, LO, Y, PC, Z plus select
// encoding and sticky multi-driver flag. Option: BANK_R0_ZERO_EN.
module bus_dest_bank #(
    parameter int WIDTH   = 32,
    parameter int NUM_GPR = 16
) (
    input  logic           clock,
    input  logic           clear_n,
    bus_dest_bank_if.slave dbus
);
    import bus_pkg::*;

    logic [WIDTH-1:0]         r_gpr [NUM_GPR];
    logic [WIDTH-1:0]         r_hi;
    logic [WIDTH-1:0]         r_lo;
    logic [WIDTH-1:0]         r_y;
    logic [WIDTH-1:0]         r_pc;
    logic [WIDTH-1:0]         r_zhigh;
    logic [WIDTH-1:0]         r_zlow;
    logic                     r_multi;

    logic [NUM_GPR-1:0]       w_gpr_ld;
    logic [NUM_GPR*WIDTH-1:0] w_gpr_q;
    logic [SEL_W-1:0]         w_sel;
    logic                     w_multi_hot;

`ifdef BANK_R0_ZERO_EN
    assign w_gpr_ld = dbus.r_in & {{(NUM_GPR-1){1'b1}}, 1'b0};
`else
    assign w_gpr_ld = dbus.r_in;
`endif

    bus_select_encoder u_enc (
        .i_out_en    (dbus.out_en),
        .o_sel       (w_sel),
        .o_multi_hot (w_multi_hot)
    );

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            for (int n = 0; n < NUM_GPR; n++) begin
                r_gpr[n] <= '0;
            end
            r_hi    <= '0;
            r_lo    <= '0;
            r_y     <= '0;
            r_pc    <= '0;
            r_zhigh <= '0;
            r_zlow  <= '0;
            r_multi <= 1'b0;
        end else begin
            for (int n = 0; n < NUM_GPR; n++) begin
                if (w_gpr_ld[n]) begin
                    r_gpr[n] <= dbus.bus_in;
                end
            end
            if (dbus.hi_in) begin
                r_hi <= dbus.bus_in;
            end
            if (dbus.lo_in) begin
                r_lo <= dbus.bus_in;
            end
            if (dbus.y_in) begin
                r_y <= dbus.bus_in;
            end
            if (dbus.z_in) begin
                r_zhigh <= dbus.alu_result[2*WIDTH-1:WIDTH];
                r_zlow  <= dbus.alu_result[WIDTH-1:0];
            end
            // A bus load outranks the increment.
            if (dbus.pc_in) begin
                r_pc <= dbus.bus_in;
            end else if (dbus.pc_inc) begin
                r_pc <= r_pc + WIDTH'(1);
            end
            if (w_multi_hot) begin
                r_multi <= 1'b1;
            end
        end
    end

    always_comb begin
        w_gpr_q = '0;
        for (int n = 0; n < NUM_GPR; n++) begin
            w_gpr_q[n*WIDTH +: WIDTH] = r_gpr[n];
        end
`ifdef BANK_R0_ZERO_EN
        w_gpr_q[WIDTH-1:0] = '0;
`endif
    end

    assign dbus.gpr_q       = w_gpr_q;
    assign dbus.hi_q        = r_hi;
    assign dbus.lo_q        = r_lo;
    assign dbus.y_q         = r_y;
    assign dbus.pc_q        = r_pc;
    assign dbus.zhigh_q     = r_zhigh;
    assign dbus.zlow_q      = r_zlow;
    assign dbus.bus_select  = w_sel;
    assign dbus.multi_drive = r_multi;

endmodule

// File: tb/tb_bus_dest_bank.sv
// Self-checking bench for bus_dest_bank: select table, directed
// sequences and randomized traffic against a register-level model.
module tb_bus_dest_bank;
    import bus_pkg::*;

    logic clk = 1'b0;
    logic clear_n = 1'b0;

    always #5 clk = ~clk;

    bus_dest_bank_if bif ();

    bus_dest_bank #(.WIDTH(32), .NUM_GPR(16)) dut (
        .clock   (clk),
        .clear_n (clear_n),
        .dbus    (bif)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_gpr [16];
    logic [31:0] m_hi, m_lo, m_y, m_pc, m_zh, m_zl;
    logic        m_multi;

    typedef struct {
        logic [24:0] oe;
        logic [4:0]  sel;
    } sel_vec_t;

    sel_vec_t tbl [8];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] ref_sel(logic [24:0] oe);
        for (int k = 0; k < 25; k++) begin
            if (oe[k]) return 5'(k);
        end
        return 5'd31;
    endfunction

    task automatic idle();
        bif.r_in   = '0;
        bif.hi_in  = 1'b0;
        bif.lo_in  = 1'b0;
        bif.y_in   = 1'b0;
        bif.pc_in  = 1'b0;
        bif.z_in   = 1'b0;
        bif.pc_inc = 1'b0;
        bif.out_en = '0;
    endtask

    task automatic model_edge();
        if (!clear_n) begin
            for (int n = 0; n < 16; n++) m_gpr[n] = '0;
            m_hi = '0; m_lo = '0; m_y = '0; m_pc = '0;
            m_zh = '0; m_zl = '0; m_multi = 1'b0;
        end else begin
            for (int n = 0; n < 16; n++) begin
`ifdef BANK_R0_ZERO_EN
                if (bif.r_in[n] && n != 0) m_gpr[n] = bif.bus_in;
`else
                if (bif.r_in[n]) m_gpr[n] = bif.bus_in;
`endif
            end
            if (bif.hi_in) m_hi = bif.bus_in;
            if (bif.lo_in) m_lo = bif.bus_in;
            if (bif.y_in)  m_y  = bif.bus_in;
            if (bif.z_in) begin
                m_zh = bif.alu_result[63:32];
                m_zl = bif.alu_result[31:0];
            end
            if (bif.pc_in)       m_pc = bif.bus_in;
            else if (bif.pc_inc) m_pc = 32'((64'(m_pc) + 1) % 64'h1_0000_0000);
            if ($countones(bif.out_en) > 1) m_multi = 1'b1;
        end
    endtask

    task automatic check_all(string tag);
        for (int n = 0; n < 16; n++) begin
            chk($sformatf("%s_r%0d", tag, n),
                64'(bif.gpr_q[32*n +: 32]), 64'(m_gpr[n]));
        end
        chk({tag, "_hi"}, 64'(bif.hi_q), 64'(m_hi));
        chk({tag, "_lo"}, 64'(bif.lo_q), 64'(m_lo));
        chk({tag, "_y"}, 64'(bif.y_q), 64'(m_y));
        chk({tag, "_pc"}, 64'(bif.pc_q), 64'(m_pc));
        chk({tag, "_zh"}, 64'(bif.zhigh_q), 64'(m_zh));
        chk({tag, "_zl"}, 64'(bif.zlow_q), 64'(m_zl));
        chk({tag, "_multi"}, 64'(bif.multi_drive), 64'(m_multi));
        chk({tag, "_sel"}, 64'(bif.bus_select), 64'(ref_sel(bif.out_en)));
    endtask

    task automatic step(string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        tbl[0] = '{25'(1) << 21, 5'd21};
        tbl[1] = '{25'd0, 5'd31};
        tbl[2] = '{(25'(1) << 4) | (25'(1) << 17), 5'd4};
        tbl[3] = '{25'd1, 5'd0};
        tbl[4] = '{25'(1) << 24, 5'd24};
        tbl[5] = '{{25{1'b1}}, 5'd0};
        tbl[6] = '{(25'(1) << 22) | (25'(1) << 23), 5'd22};
        tbl[7] = '{25'(1) << 16, 5'd16};

        // Reset with everything asserted
        clear_n        = 1'b0;
        bif.bus_in     = 32'hDEADBEEF;
        bif.alu_result = 64'h1111_2222_3333_4444;
        bif.r_in       = '1;
        bif.hi_in      = 1'b1;
        bif.lo_in      = 1'b1;
        bif.y_in       = 1'b1;
        bif.pc_in      = 1'b1;
        bif.z_in       = 1'b1;
        bif.pc_inc     = 1'b1;
        bif.out_en     = '1;
        step("reset");
        chk("reset_multi0", 64'(bif.multi_drive), 64'd0);
        chk("reset_pc0", 64'(bif.pc_q), 64'd0);
        chk("reset_gpr0", 64'(bif.gpr_q[63:0]), 64'd0);

        clear_n = 1'b1;
        idle();

        // Combinational select table, kept clear of rising edges
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bif.out_en = tbl[i].oe;
            #1;
            chk($sformatf("sel_tbl%0d", i), 64'(bif.bus_select), 64'(tbl[i].sel));
            bif.out_en = '0;
        end

        // GPR loads
        bif.r_in   = 16'hFFFF;
        bif.bus_in = 32'hA5A5A5A5;
        step("fill");
        bif.r_in   = 16'h0028;
        bif.bus_in = 32'h12345678;
        step("r3r5");
        chk("r3_val", 64'(bif.gpr_q[3*32 +: 32]), 64'h12345678);
        chk("r5_val", 64'(bif.gpr_q[5*32 +: 32]), 64'h12345678);
        chk("r4_kept", 64'(bif.gpr_q[4*32 +: 32]), 64'hA5A5A5A5);
        idle();

        // PC wrap and priority
        bif.pc_in  = 1'b1;
        bif.bus_in = 32'hFFFFFFFF;
        step("pc_ld");
        idle();
        bif.pc_inc = 1'b1;
        step("pc_wrap");
        chk("pc_wrap0", 64'(bif.pc_q), 64'd0);
        bif.pc_in  = 1'b1;
        bif.bus_in = 32'h40;
        step("pc_prio");
        chk("pc_prio40", 64'(bif.pc_q), 64'h40);
        idle();

        // Z from ALU only
        bif.z_in       = 1'b1;
        bif.alu_result = 64'h00000001_80000000;
        bif.bus_in     = 32'hDEADBEEF;
        step("z");
        chk("zhigh1", 64'(bif.zhigh_q), 64'h1);
        chk("zlow8", 64'(bif.zlow_q), 64'h80000000);
        idle();

        // R0 option
        bif.r_in   = 16'h0001;
        bif.bus_in = 32'hFF;
        step("r0");
`ifdef BANK_R0_ZERO_EN
        chk("r0_val", 64'(bif.gpr_q[31:0]), 64'h0);
`else
        chk("r0_val", 64'(bif.gpr_q[31:0]), 64'hFF);
`endif
        idle();

        // Read-during-load: R3 <- R3
        bif.out_en = 25'(1) << 3;
        bif.r_in   = 16'h0008;
        bif.bus_in = m_gpr[3];
        step("r3self");
        idle();

        // Sticky multi-drive
        chk("multi_pre", 64'(bif.multi_drive), 64'd0);
        bif.out_en = (25'(1) << 4) | (25'(1) << 17);
        #1;
        chk("multi_sel4", 64'(bif.bus_select), 64'd4);
        step("multi_set");
        chk("multi_set1", 64'(bif.multi_drive), 64'd1);
        idle();
        step("multi_hold1");
        step("multi_hold2");
        chk("multi_sticky", 64'(bif.multi_drive), 64'd1);
        clear_n = 1'b0;
        step("multi_clr");
        chk("multi_clr0", 64'(bif.multi_drive), 64'd0);
        clear_n = 1'b1;

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            int mode;
            clear_n        = ($urandom_range(0, 39) != 0);
            bif.bus_in     = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFF : $urandom;
            bif.alu_result = {$urandom, $urandom};
            bif.r_in       = 16'($urandom & $urandom);
            bif.hi_in      = ($urandom_range(0, 3) == 0);
            bif.lo_in      = ($urandom_range(0, 3) == 0);
            bif.y_in       = ($urandom_range(0, 3) == 0);
            bif.z_in       = ($urandom_range(0, 3) == 0);
            bif.pc_in      = ($urandom_range(0, 5) == 0);
            bif.pc_inc     = ($urandom_range(0, 1) == 0);
            mode           = $urandom_range(0, 9);
            if (mode == 0)      bif.out_en = '0;
            else if (mode == 1) bif.out_en = 25'($urandom);
            else                bif.out_en = 25'(1) << $urandom_range(0, 24);
            #1;
            chk("rnd_sel_comb", 64'(bif.bus_select), 64'(ref_sel(bif.out_en)));
            step("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
